// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Vectors are at most 32 bits wide; callers zero-extend and truncate the result.
   function automatic logic [4:0] onehot_to_index(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lowest_one.sv
// Isolates the lowest set bit of a vector and flags whether any bit is set.
module lowest_one #(
   parameter int W = 4
) (
   input  logic [W-1:0] vec,
   output logic [W-1:0] low,
   output logic         any
);

   assign low = vec & (~vec + W'(1));
   assign any = |vec;

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way round-robin arbiter; the grant stays locked until the owner releases it.
//
// state | meaning
// IDLE  | nobody owns the resource, GNT=0, VALID=0
// OWNED | GNT_IDX owns the resource until DONE or its request drops
module rr_arbiter
   import arbiter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic          CLK,
   input  logic          ASYNCRESETN,
   input  logic [N-1:0]  REQ,
   input  logic          DONE,
   output logic [N-1:0]  GNT,
   output logic [IW-1:0] GNT_IDX,
   output logic          VALID
);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] next_ptr, sel_ptr;
   logic          rel;
   logic [N-1:0]  masked, m_low, r_low, winner;
   logic          m_any, any_req;
   logic [N-1:0]  gnt_d;
   logic [IW-1:0] idx_d;
   logic          valid_d;

   // On a release the pointer moves past the owner and selection uses the moved pointer.
   always_comb begin
      next_ptr = (GNT_IDX == IW'(N - 1)) ? '0 : GNT_IDX + 1'b1;
      rel      = (state_q == OWNED) && (DONE || !(|(REQ & GNT)));
      sel_ptr  = rel ? next_ptr : ptr_q;
      masked   = REQ & ~((N'(1) << sel_ptr) - N'(1));
   end

   lowest_one #(.W(N)) u_low_masked (
      .vec (masked),
      .low (m_low),
      .any (m_any)
   );

   lowest_one #(.W(N)) u_low_req (
      .vec (REQ),
      .low (r_low),
      .any (any_req)
   );

   assign winner = m_any ? m_low : r_low;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) state_q <= IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req)         state_d = OWNED;
         OWNED:   if (rel && !any_req) state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d   = GNT;
      idx_d   = GNT_IDX;
      valid_d = VALID;
      ptr_d   = rel ? next_ptr : ptr_q;
      if (((state_q == IDLE) || rel) && any_req) begin
         gnt_d   = winner;
         idx_d   = IW'(onehot_to_index(32'(winner)));
         valid_d = 1'b1;
      end else if (rel) begin
         gnt_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         GNT     <= '0;
         GNT_IDX <= '0;
         VALID   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         GNT     <= gnt_d;
         GNT_IDX <= idx_d;
         VALID   <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter at N=4 and N=7 against a circular-scan ownership model.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req4 = '0;
   logic       done4 = 1'b0;
   logic [3:0] gnt4;
   logic [1:0] idx4;
   logic       valid4;
   logic [6:0] req7 = '0;
   logic       done7 = 1'b0;
   logic [6:0] gnt7;
   logic [2:0] idx7;
   logic       valid7;

   int n_vec = 0;
   int n_err = 0;

   // Model: owner (-1 when idle), last index, priority pointer, width.
   int m_own [2];
   int m_idx [2];
   int m_ptr [2];
   int m_n   [2];

   always #5 clk = ~clk;

   rr_arbiter #(.N(4)) u_arb4 (
      .CLK(clk), .ASYNCRESETN(rst_n), .REQ(req4), .DONE(done4),
      .GNT(gnt4), .GNT_IDX(idx4), .VALID(valid4)
   );

   rr_arbiter #(.N(7)) u_arb7 (
      .CLK(clk), .ASYNCRESETN(rst_n), .REQ(req7), .DONE(done7),
      .GNT(gnt7), .GNT_IDX(idx7), .VALID(valid7)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int scan_from(input int p, input int n, input logic [31:0] r);
      for (int k = 0; k < n; k++) begin
         if (r[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_own[k] = -1;
         m_idx[k] = 0;
         m_ptr[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input logic [31:0] r, input logic d);
      if (m_own[k] < 0) begin
         if (r != 0) begin
            m_own[k] = scan_from(m_ptr[k], m_n[k], r);
            m_idx[k] = m_own[k];
         end
      end else if (d || !r[m_own[k]]) begin
         m_ptr[k] = (m_own[k] + 1) % m_n[k];
         m_own[k] = scan_from(m_ptr[k], m_n[k], r);
         if (m_own[k] >= 0) m_idx[k] = m_own[k];
      end
   endtask

   function automatic logic [31:0] exp_gnt(input int k);
      return (m_own[k] >= 0) ? (32'h1 << m_own[k]) : 32'h0;
   endfunction

   task automatic check_all();
      check_eq("gnt4",   32'(gnt4),   exp_gnt(0));
      check_eq("idx4",   32'(idx4),   32'(m_idx[0]));
      check_eq("valid4", 32'(valid4), (m_own[0] >= 0) ? 32'h1 : 32'h0);
      check_eq("gnt7",   32'(gnt7),   exp_gnt(1));
      check_eq("idx7",   32'(idx7),   32'(m_idx[1]));
      check_eq("valid7", 32'(valid7), (m_own[1] >= 0) ? 32'h1 : 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, 32'(req4), done4);
      model_edge(1, 32'(req7), done7);
      #1;
      check_all();
   endtask

   initial begin
      m_n[0] = 4;
      m_n[1] = 7;
      model_reset();

      #12;
      check_eq("rst_gnt4",   32'(gnt4),   32'h0);
      check_eq("rst_idx4",   32'(idx4),   32'h0);
      check_eq("rst_valid4", 32'(valid4), 32'h0);
      rst_n = 1'b1;

      // Rotation with everyone requesting and releasing each cycle.
      req4 = 4'b1111; done4 = 1'b1;
      step(); check_eq("rot0", 32'(gnt4), 32'h1);
      step(); check_eq("rot1", 32'(gnt4), 32'h2);
      step(); check_eq("rot2", 32'(gnt4), 32'h4);
      step(); check_eq("rot3", 32'(gnt4), 32'h8);
      step(); check_eq("rot4", 32'(gnt4), 32'h1);

      // Lock: owner 0 withdraws, 1 takes over and holds without DONE.
      req4 = 4'b0110; done4 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(); check_eq("lock", 32'(gnt4), 32'h2);
      end
      done4 = 1'b1;
      step(); check_eq("lock_hand", 32'(gnt4), 32'h4);

      // Withdrawal of owner 2 while 3 requests.
      req4 = 4'b1000; done4 = 1'b0;
      step(); check_eq("withdraw", 32'(gnt4), 32'h8);

      // Last requester drops.
      req4 = 4'b0000;
      step();
      check_eq("last_valid", 32'(valid4), 32'h0);
      check_eq("last_idx",   32'(idx4),   32'h3);

      // Sole requester is re-granted continuously.
      req4 = 4'b0001; done4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); check_eq("sole", 32'(gnt4), 32'h1);
      end

      // Asynchronous reset mid-OWNED with GNT=0100.
      req4 = 4'b0100; done4 = 1'b0;
      step(); check_eq("pre_rst", 32'(gnt4), 32'h4);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("arst_gnt",   32'(gnt4),   32'h0);
      check_eq("arst_valid", 32'(valid4), 32'h0);
      req4 = 4'b1111;
      #2 rst_n = 1'b1;
      step(); check_eq("post_rst", 32'(gnt4), 32'h1);
      req4 = 4'b0000; done4 = 1'b1;
      step();

      // Wrap at N=7: owner 5 releases with 6 and 0 pending.
      req7 = 7'b0100000; done7 = 1'b0;
      step(); check_eq("w7_own5", 32'(idx7), 32'h5);
      req7 = 7'b1100001; done7 = 1'b1;
      step(); check_eq("w7_idx6", 32'(idx7), 32'h6);
      req7 = 7'b1000001;
      step(); check_eq("w7_idx0", 32'(idx7), 32'h0);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         req4  = 4'($urandom) & 4'($urandom | $urandom);
         req7  = 7'($urandom) & 7'($urandom);
         done4 = ($urandom_range(0, 2) == 0);
         done7 = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            #1 rst_n = 1'b1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised, registered round-robin arbiter with grant locking. Generalises the combinational 4-input lowest-set-bit arbiter to N requesters. Adds rotating priority for fairness and holds the grant across multi-cycle transfers until the owner releases it. Sits in front of shared resources (bus ports, memory banks, FIFO write sides) that several masters contend for.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `IW`, default clog2(N) (minimum 1): width of `GNT_IDX`; derived, not overridden.

- `CLK` in 1: single clock, rising edge.
- `ASYNCRESETN` in 1: reset, asynchronous assert, active-low.
- `REQ` in N: request vector; bit i high means master i wants the resource.
- `DONE` in 1: the current owner's release strobe; meaningful only while `VALID`=1.
- `GNT` out N: registered one-hot grant; all-zero when nobody owns the resource.
- `GNT_IDX` out IW: binary index of the `GNT` bit; holds its last value when `VALID`=0.
- `VALID` out 1: registered; equals OR of `GNT`.

## Operation
- Reset values: `GNT`=0, `GNT_IDX`=0, `VALID`=0, priority pointer `ptr`=0, state IDLE.
- The state machine has two states, IDLE and OWNED.
- Winner selection (combinational), with `m = REQ & ~((1<<ptr)-1)`:
  - if `m`≠0, winner = lowest set bit of `m`;
  - otherwise winner = lowest set bit of `REQ`.
  - Lowest-bit isolation is `x & (~x + 1)` at N bits; wrap-around is implicit.
- In IDLE:
  - if `REQ`≠0, register `GNT`=winner one-hot, `GNT_IDX`=its index and `VALID`=1, then go to OWNED;
  - otherwise stay in IDLE.
  - `DONE` is ignored in IDLE.
- In OWNED, the owner is g = `GNT_IDX`. The grant is locked; other requests do not preempt it.
- Release condition: `DONE`=1, or `REQ[g]`=0 (owner withdrew).
- On a release edge:
  - `ptr` becomes (g+1) mod N.
  - Selection is re-evaluated in the same cycle using the updated pointer value (g+1) mod N.
  - If any request remains, the new winner is registered with no idle cycle and the state stays OWNED.
  - Otherwise `GNT`=0, `VALID`=0, and the state goes to IDLE.
- `REQ[g]` is still high at release: g loses priority to every other active requester. If g is the sole requester, it is re-granted on the next cycle, so `GNT` is unchanged.
- `ptr` changes only on a release, never on an initial grant from IDLE.
- `REQ` bits that are not granted may toggle freely; they are sampled only at arbitration edges.
- Reset mid-operation clears all state asynchronously. After `ASYNCRESETN` rises, arbitration restarts from `ptr`=0.

## Timing
- Latency: `REQ` asserted in IDLE before edge k gives `GNT` valid after edge k, i.e. 1 cycle.
- Handover: `DONE` high before edge k gives the next owner's `GNT` valid after edge k. This is zero bubble cycles.
- The owner holds the resource from the first cycle of `GNT` through the cycle in which it drives `DONE`, inclusive.
- Every output is a flop; there is no combinational path from input to output.
- Fairness: with all N requesting and each owner releasing, any requester waits at most N−1 grants.

## Structure
- Package `arbiter_pkg` contains:
  - the state enum {IDLE, OWNED};
  - a `clog2` function;
  - a `onehot_to_index` function.
- Sub-module `lowest_one`, parameter `W`: combinational isolation of the lowest set bit, plus an any-bit-set flag. It is instantiated twice, once for the masked vector and once for the unmasked vector.
- Top-level contents: the `ptr` register, the state register, and the grant/index/valid registers.

## Test plan
- Reset:
  - drive `ASYNCRESETN`=0 asynchronously mid-OWNED with `GNT`=0100, N=4;
  - required: `GNT`=0, `VALID`=0 immediately, without waiting for a clock edge;
  - after reset release with `REQ`=1111, required: first grant is 0001.
- Rotation:
  - N=4, `REQ`=1111 held, `DONE`=1 every cycle;
  - required: `GNT` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Lock:
  - `REQ`=0110, `DONE`=0 for 5 cycles;
  - required: `GNT`=0010 for all 5 cycles;
  - then `DONE` pulse: required `GNT`=0100 on the next cycle with no zero cycle in between.
- Withdrawal:
  - owner 2 drops `REQ[2]` with `DONE`=0 while `REQ[3]`=1;
  - required: `GNT`=1000 next cycle and `ptr`=3.
- Sole requester:
  - `REQ`=0001 with `DONE` pulsed each cycle;
  - required: `GNT` stays 0001 continuously.
- Last requester releases:
  - owner drops `REQ` and no other request is active;
  - required: `VALID`=0 next cycle and `GNT_IDX` holds its last value.
- Wrap at N=7:
  - owner 5 releases with `REQ` bits 6 and 0 active;
  - required: `GNT_IDX`=6;
  - after its release: required `GNT_IDX`=0.
